// File: rtl/regfile_access_ctrl_pkg.sv
// Shared encodings for the register-file command sequencer.
// Op codes, FSM states and default widths.
package regfile_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int ADDR_WIDTH_DEF = 3;

   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_WRITE = 2'b01,
      OP_READ  = 2'b10,
      OP_SET   = 2'b11
   } cmd_op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RD,
      ST_RWAIT,
      ST_SETWR,
      ST_RSP
   } ctrl_state_t;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Command and response channels of the register-file sequencer.
// The master side issues commands and consumes responses.
interface regfile_access_ctrl_if
   import regfile_pkg::*;
#(
   parameter int DW = DATA_WIDTH_DEF,
   parameter int AW = ADDR_WIDTH_DEF
);

   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          wr_done;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, wr_done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, wr_done
   );

endinterface

// File: rtl/regfile_access_ctrl.sv
// Sequences read/write/bit-set commands onto the 8x16 register file.
// Every output is a register updated together with the state.
module regfile_access_ctrl
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   regfile_access_ctrl_if.slave  bus,
   output logic                  WrEn,
   output logic                  RdEn,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic [DATA_WIDTH-1:0] WrData,
   input  logic [DATA_WIDTH-1:0] RdData
);

   ctrl_state_t           r_state;
   cmd_op_t               r_op;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_cmd_ready;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic                  r_wr_done;
   logic                  r_wr_en;
   logic                  r_rd_en;
   logic [ADDR_WIDTH-1:0] r_address;
   logic [DATA_WIDTH-1:0] r_wr_data;
   cmd_op_t               w_op;

   assign w_op = cmd_op_t'(bus.cmd_op);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_op        <= OP_NOP;
         r_data      <= '0;
         r_cmd_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_wr_done   <= 1'b0;
         r_wr_en     <= 1'b0;
         r_rd_en     <= 1'b0;
         r_address   <= '0;
         r_wr_data   <= '0;
      end else begin
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
         r_wr_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               r_cmd_ready <= 1'b1;
               if (bus.cmd_valid && r_cmd_ready) begin
                  r_op   <= w_op;
                  r_data <= bus.cmd_data;
                  unique case (w_op)
                     OP_NOP: ;
                     OP_WRITE: begin
                        r_state     <= ST_WR;
                        r_cmd_ready <= 1'b0;
                        r_wr_en     <= 1'b1;
                        r_wr_done   <= 1'b1;
                        r_address   <= bus.cmd_addr;
                        r_wr_data   <= bus.cmd_data;
                     end
                     OP_READ, OP_SET: begin
                        r_state     <= ST_RD;
                        r_cmd_ready <= 1'b0;
                        r_rd_en     <= 1'b1;
                        r_address   <= bus.cmd_addr;
                     end
                  endcase
               end
            end
            ST_WR: begin
               r_state     <= ST_IDLE;
               r_cmd_ready <= 1'b1;
            end
            ST_RD: r_state <= ST_RWAIT;
            ST_RWAIT: begin
               // RdData is the file's registered output of the RD cycle
               r_rsp_data <= RdData;
               if (r_op == OP_SET) begin
                  r_state   <= ST_SETWR;
                  r_wr_en   <= 1'b1;
                  r_wr_done <= 1'b1;
                  r_wr_data <= RdData | r_data;
               end else begin
                  r_state     <= ST_RSP;
                  r_rsp_valid <= 1'b1;
               end
            end
            ST_SETWR: begin
               r_state     <= ST_RSP;
               r_rsp_valid <= 1'b1;
            end
            ST_RSP: begin
               if (bus.rsp_ready) begin
                  r_state     <= ST_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cmd_ready <= 1'b0;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmd_ready = r_cmd_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.wr_done   = r_wr_done;
   assign WrEn          = r_wr_en;
   assign RdEn          = r_rd_en;
   assign Address       = r_address;
   assign WrData        = r_wr_data;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for the sequencer paired with a behavioural 8x16 file.
// Each task drives one scenario and checks its own expectations.
module tb_regfile_access_ctrl;

   logic        CLK;
   logic        RST;
   logic        WrEn;
   logic        RdEn;
   logic [2:0]  Address;
   logic [15:0] WrData;
   logic [15:0] RdData;
   logic [15:0] mem [8];

   int n_checks;
   int n_fail;
   int wr_cnt;

   regfile_access_ctrl_if #(.DW(16), .AW(3)) bus ();

   regfile_access_ctrl #(
      .DATA_WIDTH(16),
      .ADDR_WIDTH(3)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .bus     (bus),
      .WrEn    (WrEn),
      .RdEn    (RdEn),
      .Address (Address),
      .WrData  (WrData),
      .RdData  (RdData)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // register file: write and registered read on the same edge
   always @(posedge CLK) begin
      if (WrEn) mem[Address] <= WrData;
      if (RdEn) RdData <= mem[Address];
   end

   always @(negedge CLK) begin
      if (WrEn) wr_cnt++;
      n_checks++;
      if (WrEn && RdEn) begin
         n_fail++;
         $display("FAIL wr_rd_exclusive: WrEn=%b RdEn=%b required not both", WrEn, RdEn);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [2:0] a,
                           input logic [15:0] d);
      bit done;
      done = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_addr  = a;
      bus.cmd_data  = d;
      for (int i = 0; i < 20 && !done; i++) begin
         if (bus.cmd_ready) done = 1;
         tick();
      end
      bus.cmd_valid = 1'b0;
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL cmd_accept_timeout: accepted=0 required 1");
      end
   endtask

   task automatic read_addr(input logic [2:0] a, output logic [15:0] d);
      bit got;
      got = 0;
      d = 'x;
      send_cmd(2'b10, a, 16'h0);
      for (int i = 0; i < 10 && !got; i++) begin
         if (bus.rsp_valid) got = 1;
         else tick();
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL rsp_timeout: rsp_valid=0 required 1 (addr %0d)", a);
      end
      d = bus.rsp_data;
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({bus.cmd_ready, bus.rsp_valid, bus.wr_done, WrEn, RdEn} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: rdy/rv/wd/we/re=%b required 00000",
                  {bus.cmd_ready, bus.rsp_valid, bus.wr_done, WrEn, RdEn});
      end
      n_checks++;
      if ({bus.rsp_data, Address, WrData} !== 35'h0) begin
         n_fail++;
         $display("FAIL reset_data: rsp=%h addr=%h wd=%h required 0",
                  bus.rsp_data, Address, WrData);
      end
      RST = 1'b0;
      tick();
      n_checks++;
      if (bus.cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b required 1", bus.cmd_ready);
      end
   endtask

   task automatic test_write();
      send_cmd(2'b01, 3'd3, 16'hA5A5);
      n_checks++;
      if ({WrEn, RdEn, bus.wr_done, Address, WrData} !== {3'b101, 3'd3, 16'hA5A5}) begin
         n_fail++;
         $display("FAIL write_strobe: we/re/wd=%b%b%b addr=%0d data=%h required 101 3 a5a5",
                  WrEn, RdEn, bus.wr_done, Address, WrData);
      end
      tick();
      n_checks++;
      if ({WrEn, RdEn, bus.wr_done, bus.cmd_ready} !== 4'b0001) begin
         n_fail++;
         $display("FAIL write_end: we/re/wd/rdy=%b required 0001",
                  {WrEn, RdEn, bus.wr_done, bus.cmd_ready});
      end
   endtask

   task automatic test_read_hold();
      bus.rsp_ready = 1'b0;
      send_cmd(2'b10, 3'd3, 16'hFFFF);
      n_checks++;
      if ({RdEn, WrEn, Address} !== {2'b10, 3'd3}) begin
         n_fail++;
         $display("FAIL read_strobe: re/we=%b%b addr=%0d required 10 3", RdEn, WrEn, Address);
      end
      tick();
      n_checks++;
      if ({RdEn, bus.rsp_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL read_rwait: re/rv=%b required 00", {RdEn, bus.rsp_valid});
      end
      tick();
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'hA5A5) begin
         n_fail++;
         $display("FAIL read_latency: rv=%b data=%h required 1 a5a5", bus.rsp_valid, bus.rsp_data);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_data} !== {2'b10, 16'hA5A5}) begin
            n_fail++;
            $display("FAIL read_hold: rv=%b rdy=%b data=%h required 1 0 a5a5",
                     bus.rsp_valid, bus.cmd_ready, bus.rsp_data);
         end
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      n_checks++;
      if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL read_release: rv/rdy=%b required 01", {bus.rsp_valid, bus.cmd_ready});
      end
   endtask

   task automatic test_set();
      logic [15:0] d;
      send_cmd(2'b11, 3'd3, 16'h0F00);
      tick();
      tick();
      n_checks++;
      if ({WrEn, bus.wr_done, Address, WrData, bus.rsp_valid} !== {2'b11, 3'd3, 16'hAFA5, 1'b0}) begin
         n_fail++;
         $display("FAIL set_write: we/wd=%b%b addr=%0d data=%h rv=%b required 11 3 afa5 0",
                  WrEn, bus.wr_done, Address, WrData, bus.rsp_valid);
      end
      tick();
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'hA5A5 || WrEn !== 1'b0) begin
         n_fail++;
         $display("FAIL set_rsp: rv=%b data=%h we=%b required 1 a5a5 0",
                  bus.rsp_valid, bus.rsp_data, WrEn);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      read_addr(3'd3, d);
      n_checks++;
      if (d !== 16'hAFA5) begin
         n_fail++;
         $display("FAIL set_readback: got %h required afa5", d);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] d;
      logic [15:0] exp_d;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b00;
      bus.cmd_addr  = 3'd6;
      bus.cmd_data  = 16'hDEAD;
      tick();
      n_checks++;
      if ({WrEn, RdEn, bus.wr_done, bus.cmd_ready} !== 4'b0001) begin
         n_fail++;
         $display("FAIL nop: we/re/wd/rdy=%b required 0001",
                  {WrEn, RdEn, bus.wr_done, bus.cmd_ready});
      end
      for (int i = 0; i < 8; i++) begin
         bus.cmd_op   = 2'b01;
         bus.cmd_addr = 3'(i);
         bus.cmd_data = 16'h1000 + 16'(i) * 16'h0111;
         tick();
         n_checks++;
         if ({WrEn, bus.cmd_ready, Address, WrData} !== {2'b10, 3'(i), 16'h1000 + 16'(i) * 16'h0111}) begin
            n_fail++;
            $display("FAIL b2b_write[%0d]: we=%b rdy=%b addr=%0d data=%h", i,
                     WrEn, bus.cmd_ready, Address, WrData);
         end
         tick();
         n_checks++;
         if ({WrEn, bus.cmd_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_gap[%0d]: we/rdy=%b required 01", i, {WrEn, bus.cmd_ready});
         end
      end
      bus.cmd_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_d = 16'h1000 + 16'(i) * 16'h0111;
         read_addr(3'(i), d);
         n_checks++;
         if (d !== exp_d) begin
            n_fail++;
            $display("FAIL b2b_readback[%0d]: got %h required %h", i, d, exp_d);
         end
      end
   endtask

   task automatic test_reset_mid_set();
      logic [15:0] d;
      int cnt0;
      cnt0 = wr_cnt;
      send_cmd(2'b11, 3'd5, 16'hFFFF);
      tick();
      RST = 1'b1;
      tick();
      n_checks++;
      if ({bus.cmd_ready, bus.rsp_valid, bus.wr_done, WrEn, RdEn} !== 5'b0 ||
          {bus.rsp_data, Address, WrData} !== 35'h0) begin
         n_fail++;
         $display("FAIL midset_reset_outputs: rdy/rv/wd/we/re=%b rsp=%h addr=%h wd=%h required 0",
                  {bus.cmd_ready, bus.rsp_valid, bus.wr_done, WrEn, RdEn},
                  bus.rsp_data, Address, WrData);
      end
      RST = 1'b0;
      tick();
      n_checks++;
      if (bus.cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midset_release_ready: got %b required 1", bus.cmd_ready);
      end
      tick();
      tick();
      tick();
      n_checks++;
      if (wr_cnt != cnt0) begin
         n_fail++;
         $display("FAIL midset_no_write: write cycles %0d required %0d", wr_cnt, cnt0);
      end
      read_addr(3'd5, d);
      n_checks++;
      if (d !== 16'h1555) begin
         n_fail++;
         $display("FAIL midset_unchanged: got %h required 1555", d);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      wr_cnt   = 0;
      RdData   = '0;
      for (int i = 0; i < 8; i++) mem[i] = '0;
      RST           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_addr  = '0;
      bus.cmd_data  = '0;
      bus.rsp_ready = 1'b0;
      test_reset();
      test_write();
      test_read_hold();
      test_set();
      test_back_to_back();
      test_reset_mid_set();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
